// File: rtl/bf_weight_scheduler_pkg.sv
// bf_ctrl_pkg: shared types and defaults for the beamforming weight scheduler.
//   sched_state_t : scheduler FSM states (IDLE, RUN, ARMED, DRAIN)
//   cweight_t     : one complex weight, signed real/imag halves
//   DEFAULT_*     : default weight width and multiplier pipeline depth
package bf_ctrl_pkg;

    localparam int DEFAULT_WEIGHT_WIDTH = 8;
    localparam int DEFAULT_PIPE_DELAY   = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ARMED,
        DRAIN
    } sched_state_t;

    // "real" is a reserved word, hence the short field names.
    typedef struct packed {
        logic signed [DEFAULT_WEIGHT_WIDTH-1:0] re;
        logic signed [DEFAULT_WEIGHT_WIDTH-1:0] im;
    } cweight_t;

endpackage

// File: rtl/bf_weight_scheduler_if.sv
// bf_weight_scheduler_if: configuration bus and multiplier-handshake tap.
//   cfg_wr_en/cfg_wr_chan/cfg_wr_real/cfg_wr_imag : shadow weight write port
//   cfg_commit      : one-cycle request to swap shadow into active
//   commit_pending  : a commit is waiting for its swap
//   mon_tvalid/mon_tready/mon_tlast : tap of the multiplier input handshake
//   gate_open       : ANDed externally into upstream tready
// master = software/stream side, slave = scheduler.
interface bf_weight_scheduler_if #(
    parameter int CH_WIDTH     = 2,
    parameter int WEIGHT_WIDTH = 8
);

    logic                    cfg_wr_en;
    logic [CH_WIDTH-1:0]     cfg_wr_chan;
    logic [WEIGHT_WIDTH-1:0] cfg_wr_real;
    logic [WEIGHT_WIDTH-1:0] cfg_wr_imag;
    logic                    cfg_commit;
    logic                    commit_pending;
    logic                    mon_tvalid;
    logic                    mon_tready;
    logic                    mon_tlast;
    logic                    gate_open;

    modport master (
        output cfg_wr_en, cfg_wr_chan, cfg_wr_real, cfg_wr_imag, cfg_commit,
        output mon_tvalid, mon_tready, mon_tlast,
        input  commit_pending, gate_open
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_chan, cfg_wr_real, cfg_wr_imag, cfg_commit,
        input  mon_tvalid, mon_tready, mon_tlast,
        output commit_pending, gate_open
    );

endinterface

// File: rtl/bf_weight_scheduler_bank.sv
// bf_weight_bank: shadow and active complex weight for one channel.
//   clock, resetn : clock and async active-low reset
//   wr_en, wr_data: shadow write port
//   swap          : copy shadow into active on this edge
//   active        : weight currently applied by the multiplier
module bf_weight_bank
    import bf_ctrl_pkg::*;
(
    input  logic     clock,
    input  logic     resetn,
    input  logic     wr_en,
    input  cweight_t wr_data,
    input  logic     swap,
    output cweight_t active
);

    cweight_t shadow;

    // A write and a swap on the same edge: active takes the old shadow,
    // shadow takes the new data (both read pre-edge values).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (swap) begin
                active <= shadow;
            end
            if (wr_en) begin
                shadow <= wr_data;
            end
        end
    end

endmodule

// File: rtl/bf_weight_scheduler.sv
// bf_weight_scheduler: owns the beamforming weights of NUM_CHANNELS multipliers
// and swaps shadow to active only at a frame boundary after the pipeline drains.
//   clock, resetn : clock and async active-low reset
//   bus           : config write/commit port and multiplier handshake tap (slave)
//   bWeight_real/bWeight_imag : active weights, channel c at [c*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   swap_done     : one-cycle pulse in the first cycle new weights are active
//   frame_count   : wrapping count of accepted tlast beats
module bf_weight_scheduler
    import bf_ctrl_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH,
    parameter int CH_WIDTH     = $clog2(NUM_CHANNELS),
    parameter int PIPE_DELAY   = DEFAULT_PIPE_DELAY,
    parameter int FCNT_WIDTH   = 16
) (
    input  logic                             clock,
    input  logic                             resetn,
    bf_weight_scheduler_if.slave             bus,
    output logic [NUM_CHANNELS*WEIGHT_WIDTH-1:0] bWeight_real,
    output logic [NUM_CHANNELS*WEIGHT_WIDTH-1:0] bWeight_imag,
    output logic                             swap_done,
    output logic [FCNT_WIDTH-1:0]            frame_count
);

    // Drain counter needs at least one bit even for PIPE_DELAY == 1.
    localparam int CNT_WIDTH = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;

    sched_state_t         state, state_n;
    logic [CNT_WIDTH-1:0] drain_cnt, drain_cnt_n;
    logic                 rearm, rearm_n;
    logic                 pending, pending_n;
    logic                 gate_q, gate_n;
    logic                 do_swap;
    logic                 frame_end;
    cweight_t             active_w [NUM_CHANNELS];

    assign frame_end = bus.mon_tvalid && bus.mon_tready && bus.mon_tlast;

    // Next-state logic. In RUN a commit and an fe in the same cycle only arms;
    // the boundary must be a later fe. A commit on the final DRAIN cycle still
    // counts as a re-arm request.
    always_comb begin
        state_n     = state;
        drain_cnt_n = drain_cnt;
        rearm_n     = rearm;
        pending_n   = pending;
        do_swap     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cfg_commit) begin
                    do_swap = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.cfg_commit) begin
                    pending_n = 1'b1;
                    state_n   = ARMED;
                end
            end
            ARMED: begin
                if (frame_end) begin
                    drain_cnt_n = CNT_WIDTH'(PIPE_DELAY - 1);
                    state_n     = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.cfg_commit) begin
                    rearm_n = 1'b1;
                end
                if (drain_cnt == '0) begin
                    do_swap = 1'b1;
                    rearm_n = 1'b0;
                    if (rearm || bus.cfg_commit) begin
                        state_n = ARMED;
                    end else begin
                        pending_n = 1'b0;
                        state_n   = RUN;
                    end
                end else begin
                    drain_cnt_n = drain_cnt - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        gate_n = (state_n == RUN) || (state_n == ARMED);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            drain_cnt <= '0;
            rearm     <= 1'b0;
            pending   <= 1'b0;
            gate_q    <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_cnt_n;
            rearm     <= rearm_n;
            pending   <= pending_n;
            gate_q    <= gate_n;
            swap_done <= do_swap;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            frame_count <= '0;
        end else if (frame_end) begin
            frame_count <= frame_count + FCNT_WIDTH'(1);
        end
    end

    assign bus.gate_open      = gate_q;
    assign bus.commit_pending = pending;

    // Channel indices at or above NUM_CHANNELS match no bank and are dropped.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        logic     chan_wr;
        cweight_t wr_data;

        assign chan_wr    = bus.cfg_wr_en && (bus.cfg_wr_chan == CH_WIDTH'(c));
        assign wr_data.re = bus.cfg_wr_real;
        assign wr_data.im = bus.cfg_wr_imag;

        bf_weight_bank u_bank (
            .clock   (clock),
            .resetn  (resetn),
            .wr_en   (chan_wr),
            .wr_data (wr_data),
            .swap    (do_swap),
            .active  (active_w[c])
        );

        assign bWeight_real[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = active_w[c].re;
        assign bWeight_imag[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = active_w[c].im;
    end

endmodule

// File: tb/tb_bf_weight_scheduler.sv
// tb_bf_weight_scheduler: scoreboard bench for bf_weight_scheduler.
// Stimulus tasks drive the bus on the falling edge and push the response a
// timestamp-based reference model predicts; a monitor pops and compares after
// each rising edge.
module tb_bf_weight_scheduler;

    localparam int NCH = 4;
    localparam int WW  = 8;
    localparam int CHW = 3;
    localparam int PD  = 3;
    localparam int FW  = 16;

    typedef struct {
        logic          gate;
        logic          pending;
        logic [FW-1:0] fcount;
        logic [NCH*WW-1:0] wr;
        logic [NCH*WW-1:0] wi;
    } status_t;

    logic              clock = 1'b0;
    logic              resetn;
    logic [NCH*WW-1:0] bWeight_real;
    logic [NCH*WW-1:0] bWeight_imag;
    logic              swap_done;
    logic [FW-1:0]     frame_count;

    bf_weight_scheduler_if #(.CH_WIDTH(CHW), .WEIGHT_WIDTH(WW)) bus ();

    bf_weight_scheduler #(
        .NUM_CHANNELS (NCH),
        .WEIGHT_WIDTH (WW),
        .CH_WIDTH     (CHW),
        .PIPE_DELAY   (PD),
        .FCNT_WIDTH   (FW)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .bus          (bus),
        .bWeight_real (bWeight_real),
        .bWeight_imag (bWeight_imag),
        .swap_done    (swap_done),
        .frame_count  (frame_count)
    );

    always #5 clock = ~clock;

    int tb_cycle = 0;
    always @(posedge clock) tb_cycle <= tb_cycle + 1;

    int checks = 0;
    int passes = 0;

    // Reference model: weight banks as arrays, the drain as a due timestamp.
    logic [WW-1:0] sh_re [NCH];
    logic [WW-1:0] sh_im [NCH];
    logic [WW-1:0] ac_re [NCH];
    logic [WW-1:0] ac_im [NCH];
    bit            m_started;
    bit            m_pending;
    bit            m_rearm;
    int            m_swap_due;
    logic [FW-1:0] m_fcount;

    status_t status_q [$];
    int      swap_q [$];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, tb_cycle);
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            sh_re[i] = '0; sh_im[i] = '0; ac_re[i] = '0; ac_im[i] = '0;
        end
        m_started  = 0;
        m_pending  = 0;
        m_rearm    = 0;
        m_swap_due = -1;
        m_fcount   = '0;
        status_q.delete();
        swap_q.delete();
    endtask

    task automatic applyStimulus(input bit wr_en, input int chan, input logic [WW-1:0] re,
                                 input logic [WW-1:0] im, input bit commit,
                                 input bit tv, input bit tr, input bit tl);
        bit      fe;
        bit      swap_now;
        status_t rec;
        @(negedge clock);
        bus.cfg_wr_en   = wr_en;
        bus.cfg_wr_chan = CHW'(chan);
        bus.cfg_wr_real = re;
        bus.cfg_wr_imag = im;
        bus.cfg_commit  = commit;
        bus.mon_tvalid  = tv;
        bus.mon_tready  = tr;
        bus.mon_tlast   = tl;
        fe       = tv && tr && tl;
        swap_now = 0;
        if (!m_started) begin
            if (commit) begin
                swap_now  = 1;
                m_started = 1;
            end
        end else if (m_swap_due >= 0) begin
            if (commit) m_rearm = 1;
            if (tb_cycle == m_swap_due) begin
                swap_now   = 1;
                m_swap_due = -1;
                m_pending  = m_rearm;
                m_rearm    = 0;
            end
        end else if (m_pending) begin
            if (fe) m_swap_due = tb_cycle + PD;
        end else if (commit) begin
            m_pending = 1;
        end
        if (swap_now) begin
            for (int i = 0; i < NCH; i++) begin
                ac_re[i] = sh_re[i];
                ac_im[i] = sh_im[i];
            end
            swap_q.push_back(tb_cycle + 1);
        end
        if (wr_en && chan < NCH) begin
            sh_re[chan] = re;
            sh_im[chan] = im;
        end
        if (fe) m_fcount = m_fcount + 1'b1;
        rec.gate    = m_started && (m_swap_due < 0);
        rec.pending = m_pending;
        rec.fcount  = m_fcount;
        for (int i = 0; i < NCH; i++) begin
            rec.wr[i*WW +: WW] = ac_re[i];
            rec.wi[i*WW +: WW] = ac_im[i];
        end
        status_q.push_back(rec);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic afterEdge();
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset();
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("rst_gate_open", bus.gate_open, 0);
        checkOutput("rst_commit_pending", bus.commit_pending, 0);
        checkOutput("rst_swap_done", swap_done, 0);
        checkOutput("rst_weights_real", bWeight_real, 0);
        checkOutput("rst_weights_imag", bWeight_imag, 0);
        checkOutput("rst_frame_count", frame_count, 0);
        modelReset();
        bus.cfg_wr_en  = 0; bus.cfg_wr_chan = '0; bus.cfg_wr_real = '0; bus.cfg_wr_imag = '0;
        bus.cfg_commit = 0; bus.mon_tvalid  = 0;  bus.mon_tready  = 0;  bus.mon_tlast   = 0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // Monitor: status every cycle, swap expectation only when swap_done shows.
    always begin
        status_t rec;
        @(posedge clock);
        #1;
        if (resetn) begin
            if (status_q.size() > 0) begin
                rec = status_q.pop_front();
                checkOutput("gate_open", bus.gate_open, rec.gate);
                checkOutput("commit_pending", bus.commit_pending, rec.pending);
                checkOutput("frame_count", frame_count, rec.fcount);
                checkOutput("weights_real", bWeight_real, rec.wr);
                checkOutput("weights_imag", bWeight_imag, rec.wi);
            end
            if (swap_done) begin
                if (swap_q.size() == 0) checkOutput("swap_done_unexpected", swap_done, 0);
                else checkOutput("swap_cycle", tb_cycle, swap_q.pop_front());
            end else if (swap_q.size() > 0 && swap_q[0] <= tb_cycle) begin
                checkOutput("swap_done_missing", swap_done, 1);
                void'(swap_q.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        bus.cfg_wr_en  = 0; bus.cfg_wr_chan = '0; bus.cfg_wr_real = '0; bus.cfg_wr_imag = '0;
        bus.cfg_commit = 0; bus.mon_tvalid  = 0;  bus.mon_tready  = 0;  bus.mon_tlast   = 0;
        modelReset();
        applyReset();
        idle(3);

        // Commit straight from IDLE: swap on the next edge.
        applyStimulus(1, 0, 8'h40, 8'hC0, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 0, 0, 0);
        afterEdge();
        checkOutput("idle_commit_ch0_real", bWeight_real[7:0], 8'h40);
        checkOutput("idle_commit_ch0_imag", bWeight_imag[7:0], 8'hC0);
        checkOutput("idle_commit_swap_done", swap_done, 1);
        checkOutput("idle_commit_gate_open", bus.gate_open, 1);

        // Armed commit, then an fe: gate low for PD cycles, swap after.
        applyStimulus(1, 2, 8'h7F, 8'h01, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 0, 0, 0);
        idle(2);
        applyStimulus(0, 0, '0, '0, 0, 1, 1, 1);
        afterEdge();
        checkOutput("drain_gate_low_first", bus.gate_open, 0);
        idle(PD - 1);
        afterEdge();
        checkOutput("drain_gate_low_last", bus.gate_open, 0);
        checkOutput("drain_no_early_swap", bWeight_real[23:16], 8'h00);
        idle(1);
        afterEdge();
        checkOutput("drain_swap_done", swap_done, 1);
        checkOutput("drain_ch2_real", bWeight_real[23:16], 8'h7F);
        checkOutput("drain_ch2_imag", bWeight_imag[23:16], 8'h01);
        checkOutput("drain_gate_reopen", bus.gate_open, 1);

        // Shadow write landing on the swap edge itself.
        applyStimulus(1, 1, 8'h22, 8'h22, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 0, 1, 1, 1);
        idle(PD - 1);
        applyStimulus(1, 1, 8'h11, 8'h11, 0, 0, 0, 0);
        afterEdge();
        checkOutput("swapcycle_write_active_old", bWeight_real[15:8], 8'h22);
        applyStimulus(0, 0, '0, '0, 1, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 0, 1, 1, 1);
        idle(PD);
        afterEdge();
        checkOutput("swapcycle_write_later_applied", bWeight_real[15:8], 8'h11);

        // Commit during DRAIN re-arms.
        applyStimulus(0, 0, '0, '0, 1, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 0, 1, 1, 1);
        applyStimulus(0, 0, '0, '0, 1, 0, 0, 0);
        idle(PD - 1);
        afterEdge();
        checkOutput("rearm_swap_done", swap_done, 1);
        checkOutput("rearm_pending_kept", bus.commit_pending, 1);
        applyStimulus(1, 3, 8'h33, 8'h44, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 0, 1, 1, 1);
        idle(PD);
        afterEdge();
        checkOutput("rearm_second_swap", swap_done, 1);
        checkOutput("rearm_ch3_real", bWeight_real[31:24], 8'h33);
        checkOutput("rearm_pending_cleared", bus.commit_pending, 0);

        // Out-of-range channel writes touch no bank.
        applyStimulus(1, 5, 8'hAA, 8'hAA, 0, 0, 0, 0);
        applyStimulus(1, 7, 8'hBB, 8'hBB, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 0, 1, 1, 1);
        idle(PD);
        afterEdge();
        checkOutput("oob_chan_real", bWeight_real, 32'h337F1140);
        checkOutput("oob_chan_imag", bWeight_imag, 32'h440111C0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 9) < 3, int'($urandom_range(0, 7)),
                          8'($urandom), 8'($urandom), $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                          $urandom_range(0, 4) == 0);
        end
        idle(PD + 2);

        // Reset asserted in the middle of a drain.
        applyReset();
        applyStimulus(0, 0, '0, '0, 1, 0, 0, 0);
        applyStimulus(1, 0, 8'h55, 8'h55, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 0, 1, 1, 1);
        idle(1);
        applyReset();
        idle(2);

        // Frame counter wrap: 65537 accepted tlast beats from zero.
        applyStimulus(0, 0, '0, '0, 1, 0, 0, 0);
        for (int i = 0; i < 65537; i++) applyStimulus(0, 0, '0, '0, 0, 1, 1, 1);
        afterEdge();
        checkOutput("fcount_wrap", frame_count, 16'd1);
        idle(5);
        afterEdge();
        checkOutput("swap_queue_drained", swap_q.size(), 0);
        checkOutput("status_queue_drained", status_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
